imem_uart_loader: RTL and testbench

- Writer side of the instruction ROM port that the fetch stage reads (word address = pc[15:2], 32-bit data).
- Takes a byte stream from the UART receiver through a valid/ready handshake.
- Parses a length header, packs bytes little-endian into 32-bit words and drives the instruction memory write port.
- Runs while the CPU is held in reset; `done` releases the core.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_word_pack.sv | 44 ++++
 rtl/imem_uart_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_uart_loader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the UART instruction-memory loader: the loader FSM
// state type, stream framing constants and the default build parameters.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   // Stream framing: a 16-bit little-endian word count, then 4 bytes per word.
   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   // Default build: 16K-word instruction memory, ~1M idle cycles tolerated.
   localparam int          DEF_ADDR_W      = 14;
   localparam int unsigned DEF_TIMEOUT_CYC = 1000000;

   typedef enum logic [2:0] {
      IDLE,
      HDR_LO,
      HDR_HI,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/imem_word_pack.sv
// -----------------------------------------------------------------------------
// imem_word_pack
// Packs a byte stream into 32-bit words, least-significant byte first.
//
// Ports:
//   clk        system clock
//   clr        asynchronous active-low clear (index, word and word_valid)
//   byte_stb   byte_in is accepted this cycle
//   byte_in    received byte
//   word       assembled word; complete while word_valid is high
//   word_valid one-cycle pulse, the cycle after the fourth byte of a word
// -----------------------------------------------------------------------------
module imem_word_pack
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        byte_stb,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);

   logic [IDX_W-1:0] idx;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         idx        <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= byte_stb && (idx == IDX_W'(BYTES_PER_WORD - 1));
         if (byte_stb) begin
            word[8*idx +: 8] <= byte_in;
            idx              <= idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
// Loads the instruction memory from a UART byte stream while the CPU is held
// in reset. Stream: N[7:0], N[15:8], then 4*N data bytes (LSB of each word
// first). `done` releases the core; `err` flags an aborted load.
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing byte
// equal to the XOR of all data bytes before reporting done.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               single-cycle pulse that begins a load (ignored if busy)
//   rx_valid/rx_data    byte from the UART receiver
//   rx_ready            loader accepts a byte this cycle
//   mem_we/addr/wdata   instruction memory write port, one pulse per word
//   word_cnt            words written in the current load
//   busy, done, err     load status
// -----------------------------------------------------------------------------
module imem_uart_loader
   import imem_loader_pkg::*;
#(
   parameter int          ADDR_W      = DEF_ADDR_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   word_cnt,
   output logic              busy,
   output logic              done,
   output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t END_ST = CSUM;
   logic [7:0] csum;
`else
   localparam state_t END_ST = DONE;
`endif

   state_t      state, state_nxt;
   logic [7:0]  n_lo;
   logic [15:0] n_words;
   logic [15:0] hdr_n;
   logic [31:0] tmo_cnt;
   logic        accept;
   logic        start_load;
   logic        last_write;
   logic        tmo_hit;
   logic        pack_clr_q;
   logic        pack_clr;
   logic [31:0] word;
   logic        word_valid;

   assign accept     = rx_valid & rx_ready;
   assign start_load = start && (state == IDLE || state == DONE || state == ERR);
   assign hdr_n      = {rx_data, n_lo};
   // The write cycle that brings word_cnt up to N ends the data phase.
   assign last_write = word_valid && ((32'(word_cnt) + 32'd1) == 32'(n_words));
   assign tmo_hit    = (TIMEOUT_CYC != 0) && busy && !accept &&
                       (tmo_cnt == TIMEOUT_CYC - 32'd1);

   // NOTE: the packer's asynchronous clear comes from a flop, never from
   // combinational decode, so it cannot glitch; it lands one cycle after the
   // start/abort decision, well before the first data byte can arrive.
   assign pack_clr = rst & pack_clr_q;

   imem_word_pack u_pack (
      .clk        (clk),
      .clr        (pack_clr),
      .byte_stb   (accept && state == DATA),
      .byte_in    (rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_nxt = HDR_LO;
         HDR_LO:          if (accept) state_nxt = HDR_HI;
         HDR_HI: if (accept) begin
            if (hdr_n == 16'd0)                           state_nxt = END_ST;
            else if (32'(hdr_n) > (32'd1 << ADDR_W))      state_nxt = ERR;
            else                                          state_nxt = DATA;
         end
         DATA:            if (last_write) state_nxt = END_ST;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: if (accept) state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
         default:         state_nxt = IDLE;
      endcase
      if (tmo_hit) state_nxt = ERR;
   end

   // Outputs decoded from state
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      rx_ready = 1'b0;
      mem_we   = 1'b0;
      case (state)
         HDR_LO, HDR_HI, CSUM: begin
            busy     = 1'b1;
            rx_ready = 1'b1;
         end
         DATA: begin
            busy     = 1'b1;
            // Stay ready through word writes; only the final write cycle
            // refuses, since no data byte remains and the next byte belongs
            // to whatever follows the payload.
            rx_ready = !last_write;
            mem_we   = word_valid;
         end
         DONE:    done = 1'b1;
         ERR:     err  = 1'b1;
         default: ;
      endcase
   end

   assign mem_addr  = word_cnt[ADDR_W-1:0];
   assign mem_wdata = word;

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_lo       <= '0;
         n_words    <= '0;
         word_cnt   <= '0;
         tmo_cnt    <= '0;
         pack_clr_q <= 1'b1;
      end else begin
         pack_clr_q <= !(start_load || (busy && state_nxt == ERR));

         if (!busy || accept) tmo_cnt <= '0;
         else                 tmo_cnt <= tmo_cnt + 32'd1;

         if (start_load) begin
            n_lo     <= '0;
            n_words  <= '0;
            word_cnt <= '0;
         end else begin
            if (state == HDR_LO && accept) n_lo    <= rx_data;
            if (state == HDR_HI && accept) n_words <= hdr_n;
            if (mem_we)                    word_cnt <= word_cnt + 1'b1;
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         csum <= '0;
      else if (start_load)              csum <= '0;
      else if (state == DATA && accept) csum <= csum ^ rx_data;
   end
`endif

endmodule

// File: tb/tb_imem_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_uart_loader
// Self-checking bench for imem_uart_loader. Expected memory contents are
// derived from the byte stream itself (little-endian packing of 4-byte groups).
// -----------------------------------------------------------------------------
module tb_imem_uart_loader;

   localparam int ADDR_W = 14;
   localparam int TMO    = 50;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   word_cnt;
   logic              busy;
   logic              done;
   logic              err;

   int  checks   = 0;
   int  failures = 0;
   wr_t wr_q[$];

   imem_uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .word_cnt  (word_cnt),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Record every write the loader performs.
   always @(negedge clk) if (mem_we) wr_q.push_back('{mem_addr, mem_wdata});

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference model: little-endian word i of a data byte list.
   function automatic logic [31:0] exp_word(input logic [7:0] d[$], input int i);
      return {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]};
   endfunction

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Present one byte after `gap` idle cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited = 0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!rx_ready) begin
         checks++; failures++;
         $display("FAIL send_byte: byte %h not accepted within 100 cycles", b);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_load(input logic [7:0] d[$], input int n, input int max_gap);
      logic [7:0] x = 8'h00;
      send_byte(n[7:0], $urandom_range(max_gap));
      send_byte(n[15:8], $urandom_range(max_gap));
      foreach (d[i]) begin
         send_byte(d[i], $urandom_range(max_gap));
         x ^= d[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x, 0);
`endif
   endtask

   task automatic wait_end();
      int n = 0;
      while (!done && !err && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; rx_valid = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rx_ready, mem_we, busy, done, err} !== 5'b0 || word_cnt !== '0 ||
          mem_addr !== '0 || mem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: ready/we/busy/done/err=%b cnt=%0d addr=%0d wdata=%h, required all zero",
                  {rx_ready, mem_we, busy, done, err}, word_cnt, mem_addr, mem_wdata);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_ignores_rx: rx_ready=%b busy=%b, required 0 0", rx_ready, busy);
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] d[$] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      wr_q.delete();
      pulse_start();
      checks++;
      if (busy !== 1'b1 || rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_busy: busy=%b rx_ready=%b, required 1 1", busy, rx_ready);
      end
      send_load(d, 2, 0);
      wait_end();
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 15'd2 || wr_q.size() != 2) begin
         failures++;
         $display("FAIL basic_done: done=%b err=%b cnt=%0d writes=%0d, required 1 0 2 2",
                  done, err, word_cnt, wr_q.size());
      end else begin
         checks++;
         if (wr_q[0].addr !== 14'd0 || wr_q[0].data !== 32'h00A00513 ||
             wr_q[1].addr !== 14'd1 || wr_q[1].data !== 32'h00100593) begin
            failures++;
            $display("FAIL basic_words: got %0d:%h %0d:%h, required 0:00a00513 1:00100593",
                     wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data);
         end
      end
   endtask

   task automatic test_random_loads();
      for (int it = 0; it < 3; it++) begin
         int n = $urandom_range(1, 6);
         logic [7:0] d[$];
         for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
         wr_q.delete();
         pulse_start();
         send_load(d, n, 4);
         wait_end();
         checks++;
         if (done !== 1'b1 || 32'(word_cnt) != n || wr_q.size() != n) begin
            failures++;
            $display("FAIL random_load%0d: done=%b cnt=%0d writes=%0d, required 1 %0d %0d",
                     it, done, word_cnt, wr_q.size(), n, n);
         end else begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (32'(wr_q[i].addr) != i || wr_q[i].data !== exp_word(d, i)) begin
                  failures++;
                  $display("FAIL random_word%0d_%0d: got %0d:%h, required %0d:%h",
                           it, i, wr_q[i].addr, wr_q[i].data, i, exp_word(d, i));
               end
            end
         end
      end
   endtask

   task automatic test_empty();
      logic [7:0] d[$];
      wr_q.delete();
      pulse_start();
      send_load(d, 0, 0);
      wait_end();
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || word_cnt !== '0 || wr_q.size() != 0) begin
         failures++;
         $display("FAIL empty_load: done=%b err=%b cnt=%0d writes=%0d, required 1 0 0 0",
                  done, err, word_cnt, wr_q.size());
      end
   endtask

   task automatic test_oversize();
      wr_q.delete();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h40, 0);
      checks++;
      if (err !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0 || wr_q.size() != 0) begin
         failures++;
         $display("FAIL oversize: err=%b rx_ready=%b busy=%b writes=%0d, required 1 0 0 0",
                  err, rx_ready, busy, wr_q.size());
      end
      pulse_start();
      checks++;
      if (busy !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("FAIL rearm: busy=%b err=%b, required 1 0", busy, err);
      end
      wait_end();
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL header_timeout: err=%b, required 1", err);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] d[$];
      wr_q.delete();
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      repeat (TMO - 10) @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL timeout_early: err=%b busy=%b, required 0 1", err, busy);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (err !== 1'b1 || wr_q.size() != 0) begin
         failures++;
         $display("FAIL timeout: err=%b writes=%0d, required 1 0", err, wr_q.size());
      end
      // The abandoned partial word must not leak into the next load.
      for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
      pulse_start();
      send_load(d, 1, 0);
      wait_end();
      checks++;
      if (done !== 1'b1 || wr_q.size() != 1) begin
         failures++;
         $display("FAIL after_timeout: done=%b writes=%0d, required 1 1", done, wr_q.size());
      end else begin
         checks++;
         if (wr_q[0].data !== exp_word(d, 0)) begin
            failures++;
            $display("FAIL after_timeout_word: got %h, required %h", wr_q[0].data, exp_word(d, 0));
         end
      end
   endtask

   task automatic test_reset_mid_load();
      wr_q.delete();
      pulse_start();
      send_byte(8'h03, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || word_cnt !== '0 || rx_ready !== 1'b0 || wr_q.size() != 1) begin
         failures++;
         $display("FAIL reset_mid_load: busy=%b cnt=%0d rx_ready=%b writes=%0d, required 0 0 0 1",
                  busy, word_cnt, rx_ready, wr_q.size());
      end
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] s[$];
      logic [7:0] d[$];
      logic [7:0] x = 8'h00;
      int idx = 0, cyc = 0, stalls = 0, bad = 0;
      logic acc;
      for (int i = 0; i < 1024; i++) begin
         d.push_back(8'($urandom));
         x ^= d[i];
      end
      s = {8'h00, 8'h01, d};
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(x);
`endif
      wr_q.delete();
      pulse_start();
      rx_valid = 1'b1;
      while (idx < s.size() && cyc < 3000) begin
         rx_data = s[idx];
         start   = (cyc == 600);
         acc     = rx_ready;
         if (!acc && idx < 1026) stalls++;
         @(negedge clk);
         if (acc) idx++;
         cyc++;
      end
      rx_valid = 1'b0;
      start    = 1'b0;
      wait_end();
      checks++;
      if (stalls != 0 || idx != s.size()) begin
         failures++;
         $display("FAIL b2b_stream: stalls=%0d sent=%0d, required 0 %0d", stalls, idx, s.size());
      end
      checks++;
      if (done !== 1'b1 || word_cnt !== 15'd256 || wr_q.size() != 256) begin
         failures++;
         $display("FAIL b2b_done: done=%b cnt=%0d writes=%0d, required 1 256 256",
                  done, word_cnt, wr_q.size());
      end else begin
         for (int i = 0; i < 256; i++) begin
            if (32'(wr_q[i].addr) != i || wr_q[i].data !== exp_word(d, i)) begin
               if (bad == 0)
                  $display("FAIL b2b_word%0d: got %0d:%h, required %0d:%h",
                           i, wr_q[i].addr, wr_q[i].data, i, exp_word(d, i));
               bad++;
            end
         end
         checks++;
         if (bad != 0) failures++;
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] good[$] = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      wr_q.delete();
      pulse_start();
      foreach (good[i]) send_byte(good[i], 0);
      wait_end();
      checks++;
      if (done !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("FAIL csum_good: done=%b err=%b, required 1 0", done, err);
      end
      good[6] = 8'h45;
      wr_q.delete();
      pulse_start();
      foreach (good[i]) send_byte(good[i], 0);
      wait_end();
      checks++;
      if (err !== 1'b1 || wr_q.size() != 1) begin
         failures++;
         $display("FAIL csum_bad: err=%b writes=%0d, required 1 1", err, wr_q.size());
      end else begin
         checks++;
         if (wr_q[0].addr !== 14'd0 || wr_q[0].data !== 32'h44332211) begin
            failures++;
            $display("FAIL csum_bad_word: got %0d:%h, required 0:44332211",
                     wr_q[0].addr, wr_q[0].data);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_oversize();
      test_timeout();
      test_reset_mid_load();
      test_random_loads();
      test_back_to_back();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
